lut_layer_sched: RTL and testbench

- Time-multiplexes one shared, reconfigurable truth-table memory across all neurons of a LogicNets layer (7-bit fan-in, 2-bit output per neuron) instead of instantiating one fixed ROM per neuron.
- Accepts a pre-gathered vector of per-neuron 7-bit addresses, evaluates one neuron per cycle and returns the packed layer output over valid/ready.
- Provides a config write port to load tables at runtime. Sits between the readout feature-gathering stage and the next layer.

---
 rtl/lut_layer_sched_if.sv | 41 ++++
 rtl/lut_layer_sched.sv | 119 +++++++++++
 tb/tb_lut_layer_sched.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_sched_if.sv
// Handshake and config bundle for lut_layer_sched.
//
// Valid/ready rule for in_* and out_*: a transfer happens on a rising clk
// edge where valid and ready are both 1. A valid source keeps valid and
// data stable until that edge. Ready never depends combinationally on the
// matching valid. The config port is a strobe: a write is taken on an edge
// where cfg_we and cfg_ready are both 1.
//
// Signals:
//   cfg_we / cfg_neuron / cfg_addr / cfg_data : truth-table write request
//   cfg_ready                                 : write taken this cycle
//   in_valid / in_ready / in_data             : packed per-neuron addresses
//   out_valid / out_ready / out_data          : packed per-neuron results
interface lut_layer_sched_if #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_BITS     = 7,
  parameter int OUT_BITS    = 2,
  parameter int NIDX_W      = $clog2(NUM_NEURONS) + 1
);
  logic                            cfg_we;
  logic [NIDX_W-1:0]               cfg_neuron;
  logic [IN_BITS-1:0]              cfg_addr;
  logic [OUT_BITS-1:0]             cfg_data;
  logic                            cfg_ready;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

  modport master (
    output cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_neuron, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_layer_sched.sv
// Shared truth-table evaluator for one LogicNets layer. One memory holds
// the tables of every neuron. An accepted address vector is walked one
// neuron per cycle, and the packed layer result is returned over out_*.
//
// Ports:
//   clk, rst    : rising-edge clock; asynchronous active-high reset
//   bus         : config, input and output handshakes (slave side)
//   busy        : FSM is not IDLE
//   frame_count : completed output handshakes, wraps at 16 bits
//   state_dbg   : raw FSM state (0 IDLE, 1 RUN, 2 DONE)
module lut_layer_sched #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_BITS     = 7,
  parameter int OUT_BITS    = 2,
  parameter int NIDX_W      = $clog2(NUM_NEURONS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  lut_layer_sched_if.slave  bus,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [1:0]        state_dbg
);
  localparam int MEM_DEPTH = NUM_NEURONS << IN_BITS;
  localparam int MA_W      = $clog2(MEM_DEPTH);
  localparam logic [NIDX_W-1:0] N_L  = NIDX_W'(NUM_NEURONS);
  localparam logic [NIDX_W-1:0] LAST = NIDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [OUT_BITS-1:0]             mem [MEM_DEPTH];
  logic [OUT_BITS-1:0]             rdata;
  logic [NUM_NEURONS*IN_BITS-1:0]  vec_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_q;
  logic [NIDX_W-1:0]               issue_cnt;
  logic [NIDX_W-1:0]               rd_idx;
  logic                            rd_vld;
  logic                            accept, issue_en, wr_commit, handshake;
  logic [IN_BITS-1:0]              rslice;
  logic [MA_W-1:0]                 waddr, raddr;

  // Table entry (neuron, addr) lives at neuron * 2^IN_BITS + addr.
  assign waddr  = (MA_W'(bus.cfg_neuron) << IN_BITS) | MA_W'(bus.cfg_addr);
  assign rslice = vec_q[issue_cnt*IN_BITS +: IN_BITS];
  assign raddr  = (MA_W'(issue_cnt) << IN_BITS) | MA_W'(rslice);

  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.cfg_ready = 1'b0;
    accept        = 1'b0;
    wr_commit     = 1'b0;
    issue_en      = 1'b0;
    handshake     = 1'b0;
    case (state_q)
      IDLE: begin
        // A config write in the same cycle wins over a new input vector.
        bus.cfg_ready = 1'b1;
        bus.in_ready  = !bus.cfg_we;
        // Writes to neurons outside the layer are acknowledged but dropped.
        wr_commit     = bus.cfg_we && (bus.cfg_neuron < N_L);
        accept        = bus.in_valid && !bus.cfg_we;
        if (accept) state_d = RUN;
      end
      RUN: begin
        issue_en = (issue_cnt < N_L);
        // The final slice is written on the same edge that enters DONE.
        if (rd_vld && rd_idx == LAST) state_d = DONE;
      end
      DONE: begin
        handshake = bus.out_ready;
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table storage is deliberately outside the reset domain so tables
  // survive rst.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[waddr] <= bus.cfg_data;
    if (issue_en)  rdata      <= mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q       <= '0;
      issue_cnt   <= '0;
      rd_idx      <= '0;
      rd_vld      <= 1'b0;
      out_q       <= '0;
      frame_count <= '0;
    end else begin
      if (accept) begin
        vec_q     <= bus.in_data;
        issue_cnt <= '0;
      end else if (issue_en) begin
        issue_cnt <= issue_cnt + NIDX_W'(1);
      end
      // rd_vld/rd_idx tag the read issued last cycle, so each slice is
      // written one edge after its read.
      rd_vld <= issue_en;
      rd_idx <= issue_cnt;
      if (rd_vld) out_q[rd_idx*OUT_BITS +: OUT_BITS] <= rdata;
      if (handshake) frame_count <= frame_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_lut_layer_sched.sv
module tb_lut_layer_sched;
  localparam int N      = 8;
  localparam int IB     = 7;
  localparam int OB     = 2;
  localparam int NIDX_W = $clog2(N) + 1;
  localparam int IN_W   = N * IB;
  localparam int OUT_W  = N * OB;
  localparam int LAT    = N + 1;
  localparam int II     = N + 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] frame_count;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  lut_layer_sched_if #(.NUM_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB), .NIDX_W(NIDX_W)) bus ();

  lut_layer_sched #(.NUM_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB), .NIDX_W(NIDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .frame_count (frame_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [OB-1:0]    model_mem [N][128];
  logic [OUT_W-1:0] exp_q [$];
  int               fc_exp = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Layer output straight from the table contents: neuron k looks up its
  // own address slice in its own table.
  function automatic logic [OUT_W-1:0] model_out(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*OB +: OB] = model_mem[k][v[k*IB +: IB]];
    return r;
  endfunction

  function automatic logic [IN_W-1:0] make_vec(input logic [IB-1:0] ev, input logic [IB-1:0] od);
    logic [IN_W-1:0] v;
    for (int k = 0; k < N; k++) v[k*IB +: IB] = (k % 2 == 0) ? ev : od;
    return v;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] v;
    for (int k = 0; k < N; k++) v[k*IB +: IB] = IB'($urandom_range(0, 127));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int n, input int a, input int d);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = NIDX_W'(n);
    bus.cfg_addr   = IB'(a);
    bus.cfg_data   = OB'(d);
    if (n < N) model_mem[n][a] = OB'(d);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Called just after a negedge with the block IDLE. Submits one vector,
  // optionally pulses cfg_we during RUN, holds out_ready low for 'hold'
  // cycles after out_valid, then completes the handshake.
  task automatic send_frame(input logic [IN_W-1:0] vec, input logic [OUT_W-1:0] expv,
                            input int hold, input bit poke, input string tag);
    int waits;
    int lat;
    logic [OUT_W-1:0] e;
    bus.in_valid  = 1'b1;
    bus.in_data   = vec;
    bus.out_ready = (hold == 0);
    exp_q.push_back(expv);
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    chk({tag, " accept_wait"}, waits, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk({tag, " run_busy"}, busy, 1);
    chk({tag, " run_in_ready"}, bus.in_ready, 0);
    chk({tag, " run_cfg_ready"}, bus.cfg_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.cfg_we     = poke && (lat <= 3);
      bus.cfg_neuron = '0;
      bus.cfg_addr   = 7'h55;
      bus.cfg_data   = 2'b11;
    end
    bus.cfg_we = 1'b0;
    chk({tag, " latency"}, lat, LAT);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, " out_data"}, bus.out_data, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk({tag, " hold_valid"}, bus.out_valid, 1);
      chk({tag, " hold_data"}, bus.out_data, e);
      chk({tag, " hold_in_ready"}, bus.in_ready, 0);
      chk({tag, " hold_busy"}, busy, 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    fc_exp = (fc_exp + 1) % 65536;
    chk({tag, " post_valid"}, bus.out_valid, 0);
    chk({tag, " post_in_ready"}, bus.in_ready, 1);
    chk({tag, " post_busy"}, busy, 0);
    chk({tag, " frame_count"}, frame_count, fc_exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IB-1:0]    ev;
    logic [IB-1:0]    od;
    logic [OUT_W-1:0] expv;
    int               hold;
  } vec_t;
  vec_t tbl [6];

  // ---------------- test sequence ----------------
  initial begin
    int seen;
    int accepts;
    int frames;
    int last_acc;
    bit new_vec;
    logic [IN_W-1:0] vec;
    logic [OUT_W-1:0] e;

    tbl[0] = '{ev: 7'h55, od: 7'h55, expv: 16'hE4E4, hold: 0};
    tbl[1] = '{ev: 7'h55, od: 7'h55, expv: 16'hE4E4, hold: 5};
    tbl[2] = '{ev: 7'h00, od: 7'h00, expv: 16'h0000, hold: 0};
    tbl[3] = '{ev: 7'h55, od: 7'h00, expv: 16'h2020, hold: 1};
    tbl[4] = '{ev: 7'h00, od: 7'h55, expv: 16'hC4C4, hold: 2};
    tbl[5] = '{ev: 7'h54, od: 7'h54, expv: 16'h0000, hold: 0};

    rst            = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_neuron = '0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset state", state_dbg, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset cfg_ready", bus.cfg_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_count", frame_count, 0);

    // Neuron k: entry 0x55 holds k mod 4, every other entry 0.
    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < 128; a++) begin
        @(negedge clk);
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = NIDX_W'(n);
        bus.cfg_addr   = IB'(a);
        bus.cfg_data   = (a == 'h55) ? OB'(n % 4) : '0;
        model_mem[n][a] = (a == 'h55) ? OB'(n % 4) : '0;
      end
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;

    for (int i = 0; i < 6; i++)
      send_frame(make_vec(tbl[i].ev, tbl[i].od), tbl[i].expv, tbl[i].hold, 1'b0,
                 $sformatf("tbl%0d", i));

    // Config and input in the same IDLE cycle: config wins, input next cycle.
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = NIDX_W'(2);
    bus.cfg_addr   = '0;
    bus.cfg_data   = 2'b11;
    bus.in_valid   = 1'b1;
    bus.in_data    = '0;
    model_mem[2][0] = 2'b11;
    #1;
    chk("collide in_ready", bus.in_ready, 0);
    chk("collide cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    send_frame('0, 16'h0030, 0, 1'b0, "collide");

    // Out-of-range neuron write, then cfg_we pulses while RUN.
    cfg_write(N, 'h55, 0);
    send_frame(make_vec(7'h55, 7'h55), 16'hE4E4, 0, 1'b1, "poke");
    send_frame(make_vec(7'h55, 7'h55), 16'hE4E4, 0, 1'b0, "after_poke");

    // Reset four cycles into RUN.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = make_vec(7'h55, 7'h55);
    bus.out_ready = 1'b1;
    #1;
    chk("midrst accept_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst state", state_dbg, 0);
    chk("midrst busy", busy, 0);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst frame_count", frame_count, 0);
    chk("midrst out_data", bus.out_data, 0);
    @(negedge clk);
    rst    = 1'b0;
    fc_exp = 0;
    seen   = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrst no_out_valid", seen, 0);
    chk("midrst idle", state_dbg, 0);
    send_frame(make_vec(7'h55, 7'h55), 16'hE4E4, 0, 1'b0, "retained");

    // Random table updates, some aimed past the last neuron.
    for (int i = 0; i < 300; i++) begin
      int n;
      int a;
      int d;
      n = $urandom_range(0, N + 1);
      a = $urandom_range(0, 127);
      d = $urandom_range(0, 3);
      @(negedge clk);
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = NIDX_W'(n);
      bus.cfg_addr   = IB'(a);
      bus.cfg_data   = OB'(d);
      if (n < N) model_mem[n][a] = OB'(d);
      #1;
      chk("rand cfg_ready", bus.cfg_ready, 1);
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;

    // Back-to-back random vectors, in_valid and out_ready held high.
    accepts       = 0;
    frames        = 0;
    last_acc      = -1;
    new_vec       = 1'b0;
    vec           = rand_vec();
    bus.in_data   = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 400 && frames < 6; c++) begin
      @(negedge clk);
      if (new_vec) begin
        new_vec = 1'b0;
        if (accepts < 6) begin
          vec         = rand_vec();
          bus.in_data = vec;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        if (last_acc >= 0) chk("b2b spacing", c - last_acc, II);
        last_acc = c;
        exp_q.push_back(model_out(vec));
        accepts++;
        new_vec = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("b2b frame_count", frame_count, fc_exp);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("b2b out_data", bus.out_data, e);
        fc_exp = (fc_exp + 1) % 65536;
        frames++;
      end
    end
    chk("b2b frames_done", frames, 6);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b final frame_count", frame_count, fc_exp);
    chk("b2b final idle", state_dbg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
